// File: rtl/i2c_responder.sv
// I2C target answering 24-bit configuration writes (address + two data bytes) and
// supplying a 2-byte read-back; SCL/SDA are oversampled on clk.
module i2c_responder #(
    parameter logic [6:0] DEVICE_ADDR = 7'h1A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] tx_data,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_WR_DONE,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;

    // NOTE: state uses non-blocking assignments under an async active-low reset so
    // that every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    logic scl, sda, scl_rise, scl_fall, start_cond, stop_cond;
    assign scl        = scl_sync_q[1];
    assign sda        = sda_sync_q[1];
    assign scl_rise   = scl & ~scl_prev_q;
    assign scl_fall   = ~scl & scl_prev_q;
    // SCL must be high on both samples so an SDA change alongside an SCL edge is a data bit.
    assign start_cond = scl & scl_prev_q & sda_prev_q & ~sda;
    assign stop_cond  = scl & scl_prev_q & ~sda_prev_q & sda;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d;
    logic        byte_idx_q, byte_idx_d;
    logic        sda_oe_q, sda_oe_d;
    logic [15:0] rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;

    // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        if (start_cond) begin
            state_d    = ST_ADDR;
            bit_cnt_d  = 4'd0;
            byte_idx_d = 1'b0;
            sda_oe_d   = 1'b0;
        end else if (stop_cond) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR, ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[14:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (state_q == ST_WR_BYTE) begin
                            state_d  = ST_WR_ACK;
                            sda_oe_d = 1'b1;
                        end else if (shift_q[7:1] == DEVICE_ADDR) begin
                            state_d  = ST_ADDR_ACK;
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    // Reads leave on the ACK's rising edge so the falling edge ending it drives bit 7.
                    if (scl_rise && shift_q[0]) begin
                        shift_d   = tx_data;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RD_BYTE;
                    end else if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_WR_BYTE;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        if (byte_idx_q) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = ST_WR_DONE;
                        end else begin
                            byte_idx_d = 1'b1;
                            state_d    = ST_WR_BYTE;
                        end
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = ST_RD_ACK;
                        end else begin
                            sda_oe_d  = ~shift_q[15];
                            shift_d   = {shift_q[14:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda && !byte_idx_q) begin
                            byte_idx_d = 1'b1;
                            bit_cnt_d  = 4'd0;
                            state_d    = ST_RD_BYTE;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 16'h0000;
            byte_idx_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 16'h0000;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q == ST_ADDR_ACK) || (state_q == ST_WR_BYTE) ||
                      (state_q == ST_WR_ACK)   || (state_q == ST_WR_DONE) ||
                      (state_q == ST_RD_BYTE)  || (state_q == ST_RD_ACK);

endmodule

// File: tb/tb_i2c_responder.sv
// Bench for i2c_responder: a bit-level I2C controller model drives an open-drain bus;
// received words are checked against a queue of expected words.
module tb_i2c_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        scl = 1'b1;
    logic        sda_drv = 1'b1;
    logic        sda_oe;
    logic [15:0] tx_data = 16'h0000;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        busy;

    wire sda_bus = sda_drv & ~sda_oe;

    always #5 clk = ~clk;

    i2c_responder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl_in   (scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] exp_q[$];
    int          rx_pulses = 0;
    int          wide_pulses = 0;
    logic        rx_valid_prev = 1'b0;
    logic        oe_seen = 1'b0;

    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (rx_valid) begin
            rx_pulses++;
            if (rx_valid_prev) wide_pulses++;
            if (exp_q.size() > 0) check("rx_data_sb", rx_data, exp_q.pop_front());
        end
        rx_valid_prev = rx_valid;
    end

    task automatic quarter();
        repeat (4) @(negedge clk);
    endtask

    task automatic start_cond();
        sda_drv = 1'b1; quarter();
        scl = 1'b1;     quarter();
        sda_drv = 1'b0; quarter();
        scl = 1'b0;     quarter();
    endtask

    task automatic stop_cond();
        sda_drv = 1'b0; quarter();
        scl = 1'b1;     quarter();
        sda_drv = 1'b1; quarter();
        quarter();
    endtask

    task automatic clock_bit(input logic b, output logic seen);
        sda_drv = b; quarter();
        scl = 1'b1;  quarter();
        seen = sda_bus;
        quarter();
        scl = 1'b0;  quarter();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(~ack, s);
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        int         base;

        #1;
        check("rst_sda_oe", sda_oe, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_data", rx_data, 16'h0000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        quarter();

        // Full write
        base = rx_pulses;
        exp_q.push_back(16'h1E00);
        start_cond();
        write_byte(8'h34, a); check("t1_ack_addr", a, 1);
        check("t1_busy", busy, 1);
        write_byte(8'h1E, a); check("t1_ack_b0", a, 1);
        write_byte(8'h00, a); check("t1_ack_b1", a, 1);
        stop_cond();
        check("t1_busy_stop", busy, 0);
        check("t1_rx_data", rx_data, 16'h1E00);
        check("t1_pulses", rx_pulses - base, 1);

        // Wrong address
        base = rx_pulses;
        oe_seen = 1'b0;
        start_cond();
        write_byte(8'h36, a); check("t2_ack_addr", a, 0);
        check("t2_busy", busy, 0);
        write_byte(8'h12, a); check("t2_ack_b0", a, 0);
        write_byte(8'h34, a); check("t2_ack_b1", a, 0);
        stop_cond();
        check("t2_oe_seen", oe_seen, 0);
        check("t2_pulses", rx_pulses - base, 0);

        // Truncated write
        base = rx_pulses;
        start_cond();
        write_byte(8'h34, a); check("t3_ack_addr", a, 1);
        write_byte(8'h0A, a); check("t3_ack_b0", a, 1);
        stop_cond();
        check("t3_pulses", rx_pulses - base, 0);
        check("t3_rx_data", rx_data, 16'h1E00);

        // Extra byte after the word
        base = rx_pulses;
        exp_q.push_back(16'h0C00);
        start_cond();
        write_byte(8'h34, a); check("t4_ack_addr", a, 1);
        write_byte(8'h0C, a); check("t4_ack_b0", a, 1);
        write_byte(8'h00, a); check("t4_ack_b1", a, 1);
        write_byte(8'hFF, a); check("t4_ack_extra", a, 0);
        check("t4_busy_done", busy, 1);
        stop_cond();
        check("t4_rx_data", rx_data, 16'h0C00);
        check("t4_pulses", rx_pulses - base, 1);

        // Read-back
        base = rx_pulses;
        tx_data = 16'hA5C3;
        start_cond();
        write_byte(8'h35, a); check("t5_ack_addr", a, 1);
        read_byte(1'b1, d);   check("t5_rd_b0", d, 8'hA5);
        check("t5_busy", busy, 1);
        read_byte(1'b0, d);   check("t5_rd_b1", d, 8'hC3);
        check("t5_released", sda_oe, 0);
        check("t5_busy_nack", busy, 0);
        stop_cond();
        check("t5_pulses", rx_pulses - base, 0);

        // Reset mid-byte, then repeated START
        base = rx_pulses;
        start_cond();
        write_byte(8'h34, a); check("t6_ack_addr", a, 1);
        for (int i = 7; i >= 4; i--) clock_bit(d[i] & 1'b0, a);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6_rst_sda_oe", sda_oe, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_rx_data", rx_data, 16'h0000);
        quarter();
        reset_n = 1'b1;
        quarter();
        exp_q.push_back(16'h1234);
        start_cond();
        write_byte(8'h34, a); check("t6_ack_addr2", a, 1);
        write_byte(8'h12, a); check("t6_ack_b0", a, 1);
        write_byte(8'h34, a); check("t6_ack_b1", a, 1);
        stop_cond();
        check("t6_rx_data", rx_data, 16'h1234);
        check("t6_pulses", rx_pulses - base, 1);

        check("rx_valid_width", wide_pulses, 0);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_responder.md
# i2c_responder

I2C target (responder) that answers the 24-bit configuration transfers issued by the team's I2C write controller: one address byte followed by two data bytes, each acknowledged. It sits on the bench side of the configuration bus as a codec model and loopback target. It also serves as the in-fabric endpoint for boards that expose configuration registers over I2C. It oversamples SCL/SDA on the system clock, delivers each received 16-bit word with a one-cycle strobe, and supports a 2-byte read-back.

## Interface
- DEVICE_ADDR, 7'h1A, 7-bit target address; matches write byte 8'h34 and read byte 8'h35.
- clk  in  1  system clock; must be at least 8x SCL frequency.
- reset_n  in  1  asynchronous, active-low reset.
- scl_in  in  1  raw SCL from the bus, asynchronous.
- sda_in  in  1  raw SDA from the bus, asynchronous.
- sda_oe  out  1  1 = pull SDA low; 0 = release SDA. Open-drain only; the block never drives SDA high.
- tx_data  in  16  read-back word; sampled when a read address is acknowledged.
- rx_data  out  16  last complete received word, with the first data byte in [15:8].
- rx_valid  out  1  one-clk pulse when rx_data updates.
- busy  out  1  high from START to STOP whenever the address matched.

## Operation
- Synchronizers: scl_in and sda_in each pass through 2 flops that reset to 1, plus one history flop for edge detection. All decisions use the synchronized values.
- Bus conditions, evaluated with SCL high:
  - START = SDA falls.
  - STOP = SDA rises.
  - A START in any state, including a repeated START, clears the bit counter and enters ADDR.
  - A STOP in any state enters IDLE and releases sda_oe. A partially received word is discarded and rx_valid does not pulse.
- Data is sampled on the SCL rising edge, MSB first. sda_oe changes only on SCL falling edges.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits.
    - If bits[7:1] == DEVICE_ADDR: go to ADDR_ACK.
    - Otherwise: go to IGNORE, with sda_oe held at 0.
  - ADDR_ACK: assert sda_oe on the falling edge after bit 8 and release it on the next falling edge.
    - R/W=0: go to WR_BYTE.
    - R/W=1: latch tx_data into the shift register and go to RD_BYTE.
  - WR_BYTE: shift in 8 bits, then go to WR_ACK, which drives the ACK the same way as ADDR_ACK.
    - After byte 0: hold the byte and return to WR_BYTE.
    - After byte 1: load rx_data = {byte0, byte1} and pulse rx_valid on the SCL falling edge that ends the ACK. Then go to WR_DONE.
  - WR_DONE: any further data byte is not acknowledged (sda_oe stays 0); remain in WR_DONE until STOP or START.
  - RD_BYTE: on each SCL falling edge, sda_oe = ~shift[15] and the register shifts left. After 8 bits, release SDA and go to RD_ACK.
  - RD_ACK: sample the controller's response on the SCL rising edge.
    - SDA=0 (ACK) after byte 0: go to RD_BYTE for the low byte.
    - NACK, or after byte 1: go to IGNORE.
  - IGNORE: sda_oe = 0 until STOP or START.
- busy is 1 in ADDR_ACK, WR_BYTE, WR_ACK, WR_DONE, RD_BYTE and RD_ACK, and 0 otherwise.

## Timing
- Reset values:
  - state = IDLE.
  - sda_oe, rx_valid, busy = 0.
  - rx_data = 16'h0000.
  - Synchronizer flops = 1.
- Latency: sda_oe and rx_valid change 3 clk after the raw SCL falling edge (2 synchronizer stages + 1 register stage). Bit sampling occurs 3 clk after the raw SCL rising edge.
- rx_valid is exactly 1 clk wide; rx_data holds its value until the next valid word.
- START/STOP take priority over a bit sample detected in the same clk.
- A glitch shorter than 2 clk on SCL or SDA is not filtered. This is acceptable at the required 8x oversampling.
- reset_n asserted mid-transfer releases SDA immediately (asynchronous). After reset the block ignores the bus until the next START.

## Test plan
- Write 8'h34, 8'h1E, 8'h00 with STOP -> three ACKs (SDA low in each ack slot), rx_data = 16'h1E00, exactly one rx_valid pulse, busy falls on STOP.
- Write 8'h36 (wrong address), 8'h12, 8'h34 -> no ACK in any slot, sda_oe never 1, no rx_valid, busy stays 0.
- Write 8'h34, 8'h0A, then STOP -> two ACKs, no rx_valid, rx_data unchanged from its prior value.
- Write 8'h34, 8'h0C, 8'h00, 8'hFF -> ACKs on the first three bytes, no ACK on the fourth, rx_data = 16'h0C00, exactly one rx_valid pulse.
- tx_data = 16'hA5C3, then transfer 8'h35, controller ACKs byte 0 and NACKs byte 1 -> SDA bits read back as 10100101 then 11000011, SDA released after the NACK.
- Assert reset_n mid-way through data byte 0, deassert it, then issue repeated START + 8'h34, 8'h12, 8'h34 -> sda_oe = 0 at reset, then rx_data = 16'h1234 with one rx_valid pulse.
